// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller (8 lines x 4 words).
// Misses drive the readM/evict/finish block protocol; a dirty victim rides along on evict.
module dcache_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_LINES  = 8,
  parameter int LINE_SIZE  = 77
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cpu_read,
  input  logic                            cpu_write,
  input  logic [WORD_SIZE-1:0]            cpu_address,
  input  logic [WORD_SIZE-1:0]            cpu_write_data,
  output logic [WORD_SIZE-1:0]            cpu_read_data,
  output logic                            cpu_ready,
  output logic                            readM,
  output logic [WORD_SIZE-1:0]            address,
  input  logic [BLOCK_SIZE*WORD_SIZE-1:0] data,
  output logic [LINE_SIZE-1:0]            evict,
  input  logic                            finish,
  output logic [WORD_SIZE-1:0]            hit_count,
  output logic [WORD_SIZE-1:0]            miss_count
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(BLOCK_SIZE);
  localparam int TAG_W  = WORD_SIZE - IDX_W - OFF_W;
  localparam int DATA_W = BLOCK_SIZE * WORD_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [NUM_LINES-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [TAG_W-1:0]       tag_d  [NUM_LINES];
  logic [DATA_W-1:0]      data_q [NUM_LINES];
  logic [DATA_W-1:0]      data_d [NUM_LINES];
  logic                   cpu_ready_q, cpu_ready_d;
  logic [WORD_SIZE-1:0]   cpu_read_data_q, cpu_read_data_d;
  logic [WORD_SIZE-1:0]   hit_count_q, hit_count_d;
  logic [WORD_SIZE-1:0]   miss_count_q, miss_count_d;

  logic [IDX_W-1:0]       index;
  logic [OFF_W-1:0]       word_sel;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;

  assign index    = cpu_address[OFF_W +: IDX_W];
  assign word_sel = cpu_address[OFF_W-1:0];
  assign req_tag  = cpu_address[WORD_SIZE-1 -: TAG_W];
  assign hit      = valid_q[index] && (tag_q[index] == req_tag);

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    tag_d           = tag_q;
    data_d          = data_q;
    cpu_ready_d     = 1'b0;
    cpu_read_data_d = cpu_read_data_q;
    hit_count_d     = hit_count_q;
    miss_count_d    = miss_count_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          if (hit) begin
            if (cpu_read) begin
              cpu_read_data_d = data_q[index][int'(word_sel)*WORD_SIZE +: WORD_SIZE];
            end
            if (cpu_write) begin
              data_d[index][int'(word_sel)*WORD_SIZE +: WORD_SIZE] = cpu_write_data;
              dirty_d[index] = 1'b1;
            end
            hit_count_d = hit_count_q + WORD_SIZE'(1);
            cpu_ready_d = 1'b1;
            state_d     = RESP;
          end else begin
            miss_count_d = miss_count_q + WORD_SIZE'(1);
            state_d      = REQ;
          end
        end
      end
      REQ: begin
        if (finish) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Refill lands clean; a store miss re-dirties the line on its retried lookup.
        if (finish) begin
          data_d[index]  = data;
          tag_d[index]   = req_tag;
          valid_d[index] = 1'b1;
          dirty_d[index] = 1'b0;
          state_d        = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      cpu_ready_q     <= 1'b0;
      cpu_read_data_q <= '0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      cpu_ready_q     <= cpu_ready_d;
      cpu_read_data_q <= cpu_read_data_d;
      hit_count_q     <= hit_count_d;
      miss_count_q    <= miss_count_d;
    end
  end

  // Tag and data storage carry no reset; the valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  // readM must fall in the very cycle finish is seen in WAIT, so it is decoded, not registered.
  assign readM = (state_q == REQ) || ((state_q == WAIT) && !finish);

  assign evict = (state_q == REQ)
               ? {tag_q[index], dirty_q[index] & valid_q[index], valid_q[index], data_q[index]}
               : '0;

  assign address       = cpu_address;
  assign cpu_ready     = cpu_ready_q;
  assign cpu_read_data = cpu_read_data_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: block-memory model, CPU-view reference model
// and a scoreboard queue of expected load results.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_address;
  logic [15:0] cpu_write_data;
  logic [15:0] cpu_read_data;
  logic        cpu_ready;
  logic        readM;
  logic [15:0] address;
  logic [63:0] data;
  logic [76:0] evict;
  logic        finish;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  dcache_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .cpu_ready      (cpu_ready),
    .readM          (readM),
    .address        (address),
    .data           (data),
    .evict          (evict),
    .finish         (finish),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  // Block memory: writeback at acceptance, refill read when finish rises 5 edges later.
  logic [15:0] mem [0:4095];
  bit          memLoaded;
  logic        memFinishQ;
  logic        memBusy;
  int          memCnt;
  logic [15:0] memReqAddr;
  logic [63:0] memBlock;
  logic        memStall;

  assign finish = memFinishQ && !memStall;
  assign data   = memBlock;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      memFinishQ <= 1'b1;
      memBusy    <= 1'b0;
      memCnt     <= 0;
      if (!memLoaded) begin
        for (int k = 0; k < 4096; k++) mem[k] <= 16'h0000;
        mem[12'h023] <= 16'h6000;
        memLoaded    <= 1'b1;
      end
    end else if (memBusy) begin
      if (memCnt == 1) begin
        memBlock   <= {mem[{memReqAddr[11:2], 2'd3}], mem[{memReqAddr[11:2], 2'd2}],
                       mem[{memReqAddr[11:2], 2'd1}], mem[{memReqAddr[11:2], 2'd0}]};
        memFinishQ <= 1'b1;
        memBusy    <= 1'b0;
      end else begin
        memCnt <= memCnt - 1;
      end
    end else if (readM && finish) begin
      if (evict[65]) begin
        for (int k = 0; k < 4; k++) mem[{evict[72:66], address[4:2], 2'(k)}] <= evict[16*k +: 16];
      end
      memReqAddr <= address;
      memBusy    <= 1'b1;
      memCnt     <= 5;
      memFinishQ <= 1'b0;
    end
  end

  // Reference model: CPU-visible memory plus cache tag state.
  logic [15:0] refMem [0:4095];
  bit          mdlValid [8];
  bit          mdlDirty [8];
  logic [10:0] mdlTag   [8];
  logic [15:0] expHits;
  logic [15:0] expMisses;

  typedef struct {
    bit          isLoad;
    logic [15:0] data;
  } expT;
  expT sbQ[$];

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit isWrite, input logic [15:0] addr,
                               input logic [15:0] wdata, input int stall);
    logic [2:0]  idx;
    logic [10:0] tg;
    logic [11:0] ob;
    bit          expHit;
    logic [76:0] expEvict;
    logic [31:0] rmMask;
    logic [31:0] expMask;
    int          expLat;
    int          cyc;
    bit          done;
    expT         e;

    idx    = addr[4:2];
    tg     = addr[15:5];
    expHit = mdlValid[idx] && (mdlTag[idx] == tg);
    ob     = {mdlTag[idx][6:0], idx, 2'b00};
    expEvict = {mdlTag[idx], mdlDirty[idx], 1'b1,
                refMem[ob + 12'd3], refMem[ob + 12'd2], refMem[ob + 12'd1], refMem[ob]};
    expLat  = expHit ? 1 : 9 + stall;
    expMask = expHit ? 32'd0 : 32'((1 << (7 + stall)) - 2);

    e.isLoad = !isWrite;
    e.data   = refMem[addr[11:0]];
    sbQ.push_back(e);

    @(posedge clk);
    #1;
    cpu_read       = !isWrite;
    cpu_write      = isWrite;
    cpu_address    = addr;
    cpu_write_data = wdata;
    memStall       = (stall > 0);

    cyc    = 0;
    done   = 0;
    rmMask = '0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (readM && cyc < 32) rmMask[cyc] = 1'b1;
      if (!expHit && cyc >= 1 && cyc <= 1 + stall) begin
        if (mdlValid[idx]) checkOutput("evict_line", evict, expEvict);
        else               checkOutput("evict_invalid", evict[65:64], 2'b00);
      end
      if (memStall && cyc == stall + 1) memStall = 1'b0;
      if (cpu_ready) begin
        done = 1;
        if (sbQ.size() == 0) begin
          checkOutput("sb_nonempty", 1'b0, 1'b1);
        end else begin
          e = sbQ.pop_front();
          if (e.isLoad) checkOutput("load_data", cpu_read_data, e.data);
        end
      end else begin
        cyc++;
      end
    end
    checkOutput("completed", done, 1'b1);
    checkOutput("latency", cyc, expLat);
    checkOutput("readM_cycles", rmMask, expMask);

    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    memStall  = 1'b0;
    @(negedge clk);
    checkOutput("ready_pulse", cpu_ready, 1'b0);

    if (!expHit) begin
      expMisses     = expMisses + 16'd1;
      mdlValid[idx] = 1;
      mdlDirty[idx] = 0;
      mdlTag[idx]   = tg;
    end
    expHits = expHits + 16'd1;
    if (isWrite) begin
      refMem[addr[11:0]] = wdata;
      mdlDirty[idx]      = 1;
    end
    checkOutput("hit_count", hit_count, expHits);
    checkOutput("miss_count", miss_count, expMisses);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cpu_read       = 1'b0;
    cpu_write      = 1'b0;
    cpu_address    = '0;
    cpu_write_data = '0;
    memStall       = 1'b0;
    for (int k = 0; k < 4096; k++) refMem[k] = 16'h0000;
    refMem[12'h023] = 16'h6000;
    for (int k = 0; k < 8; k++) begin
      mdlValid[k] = 0;
      mdlDirty[k] = 0;
      mdlTag[k]   = '0;
    end
    expHits   = '0;
    expMisses = '0;

    #3 reset = 1'b1;
    #1;
    checkOutput("rst_readM", readM, 1'b0);
    checkOutput("rst_ready", cpu_ready, 1'b0);
    checkOutput("rst_hits", hit_count, 16'd0);
    checkOutput("rst_misses", miss_count, 16'd0);
    checkOutput("rst_evict", evict, 77'd0);
    checkOutput("rst_rdata", cpu_read_data, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Cold miss, hit in the same line, store hit, then a conflicting load evicting the dirty line.
    applyStimulus(1'b0, 16'h0023, 16'h0000, 0);
    applyStimulus(1'b0, 16'h0022, 16'h0000, 0);
    applyStimulus(1'b1, 16'h0023, 16'hBEEF, 0);
    applyStimulus(1'b0, 16'h0043, 16'h0000, 0);
    checkOutput("writeback_0x23", mem[12'h023], 16'hBEEF);

    // Store miss allocates, then hits; evicting it later must carry the dirty word.
    applyStimulus(1'b1, 16'h0081, 16'h1234, 0);
    applyStimulus(1'b0, 16'h0081, 16'h0000, 0);
    applyStimulus(1'b0, 16'h0001, 16'h0000, 0);
    checkOutput("writeback_0x81", mem[12'h081], 16'h1234);

    // Busy memory on REQ entry with a dirty victim.
    applyStimulus(1'b0, 16'h0004, 16'h0000, 0);
    applyStimulus(1'b1, 16'h0005, 16'hA5C3, 0);
    applyStimulus(1'b0, 16'h0044, 16'h0000, 3);

    // Reset asserted mid-miss while in WAIT.
    @(posedge clk);
    #1;
    cpu_read    = 1'b1;
    cpu_address = 16'h0060;
    repeat (4) @(negedge clk);
    checkOutput("wait_readM", readM, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_readM", readM, 1'b0);
    checkOutput("midrst_ready", cpu_ready, 1'b0);
    checkOutput("midrst_hits", hit_count, 16'd0);
    checkOutput("midrst_misses", miss_count, 16'd0);
    cpu_read = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mdlValid[k] = 0;
      mdlDirty[k] = 0;
    end
    expHits   = '0;
    expMisses = '0;
    refMem    = mem;

    applyStimulus(1'b0, 16'h0060, 16'h0000, 0);
    applyStimulus(1'b0, 16'h0081, 16'h0000, 0);
    applyStimulus(1'b0, 16'h0005, 16'h0000, 0);

    // Random mix over four tags and all indices.
    for (int n = 0; n < 24; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom_range(0, 127)), 16'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
